// File: rtl/regfile_pkg.sv
// Shared sizing constants and helpers for the MIPS32 general register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic int depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  localparam int DEPTH_DEF = depth(ADDR_W_DEF);

endpackage

// File: rtl/regfile_fwd_mux.sv
// One read port: picks the highest-index matching write, else the stored word,
// and masks the pending flag when the forwarded value is already valid.
module regfile_fwd_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]        raddr,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0]        word,
  input  logic                     busy,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rbusy
);

  logic hit;

  always_comb begin
    rdata = word;
    hit   = 1'b0;
    // Ascending scan so the last match, i.e. the highest port index, wins.
    for (int i = 0; i < NUM_WR; i++) begin
      if (we[i] && (waddr[i*ADDR_W +: ADDR_W] == raddr)) begin
        rdata = wdata[i*DATA_W +: DATA_W];
        hit   = 1'b1;
      end
    end
    rbusy = busy & ~hit;
    if ((ZERO_REG != 0) && (raddr == '0)) begin
      rdata = '0;
      rbusy = 1'b0;
    end
  end

endmodule

// File: rtl/mips_regfile_sb.sv
// Multi-port MIPS32 register file with write-to-read forwarding and a
// per-register pending scoreboard for decode-stage RAW hazard detection.
module mips_regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic [depth(ADDR_W)-1:0] busy_vec
);

  localparam int DEPTH = depth(ADDR_W);

  logic [DATA_W-1:0] rf [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [NUM_WR-1:0] wr_ok;
  logic              issue_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_wr_ok
      assign wr_ok[gi] = we[gi] &&
                         !((ZERO_REG != 0) && (waddr[gi*ADDR_W +: ADDR_W] == '0));
    end
  endgenerate

  assign issue_ok = issue_valid && !((ZERO_REG != 0) && (issue_addr == '0));

  // Later non-blocking assignments win: higher write ports override lower
  // ones, and a new issue overrides a completing write to the same register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) rf[k] <= '0;
      busy <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_ok[i]) begin
          rf[waddr[i*ADDR_W +: ADDR_W]]   <= wdata[i*DATA_W +: DATA_W];
          busy[waddr[i*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      end
      if (issue_ok) busy[issue_addr] <= 1'b1;
    end
  end

  assign busy_vec = busy;

  genvar gj;
  generate
    for (gj = 0; gj < NUM_RD; gj++) begin : g_rd
      regfile_fwd_mux #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_WR  (NUM_WR),
        .ZERO_REG(ZERO_REG)
      ) u_fwd_mux (
        .raddr(raddr[gj*ADDR_W +: ADDR_W]),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .word (rf[raddr[gj*ADDR_W +: ADDR_W]]),
        .busy (busy[raddr[gj*ADDR_W +: ADDR_W]]),
        .rdata(rdata[gj*DATA_W +: DATA_W]),
        .rbusy(rbusy[gj])
      );
    end
  endgenerate

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Bench for mips_regfile_sb: directed scenarios plus random traffic, checked
// against a small reference model through an expected-value queue.
module tb_mips_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;

  // Clock / reset
  logic          clk = 1'b0;
  logic          reset;
  logic [2*AW-1:0] raddr;
  logic [2*DW-1:0] rdata;
  logic [1:0]      rbusy;
  logic [1:0]      we;
  logic [2*AW-1:0] waddr;
  logic [2*DW-1:0] wdata;
  logic            issue_valid;
  logic [AW-1:0]   issue_addr;
  logic [31:0]     busy_vec;

  always #5 clk = ~clk;

  mips_regfile_sb dut (
    .clk        (clk),
    .reset      (reset),
    .raddr      (raddr),
    .rdata      (rdata),
    .rbusy      (rbusy),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .issue_valid(issue_valid),
    .issue_addr (issue_addr),
    .busy_vec   (busy_vec)
  );

  // Reference model state
  logic [DW-1:0] m_rf [32];
  logic [31:0]   m_busy;
  logic [32:0]   exp_q[$];   // {rbusy, rdata} per read port, port 0 first

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [32:0] model_read(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    logic          hit;
    d   = m_rf[a];
    hit = 1'b0;
    if (we[0] && waddr[AW-1:0] == a)   begin d = wdata[DW-1:0];  hit = 1'b1; end
    if (we[1] && waddr[2*AW-1:AW] == a) begin d = wdata[2*DW-1:DW]; hit = 1'b1; end
    if (a == '0) return 33'd0;
    return {m_busy[a] & ~hit, d};
  endfunction

  // Driver tasks
  task automatic drive(input logic [1:0] w, input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
                       input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
                       input logic iv, input logic [AW-1:0] ia,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    we = w;
    waddr = {wa1, wa0};
    wdata = {wd1, wd0};
    issue_valid = iv;
    issue_addr = ia;
    raddr = {ra1, ra0};
  endtask

  task automatic idle_inputs();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, raddr[AW-1:0], raddr[2*AW-1:AW]);
  endtask

  // Push expectations for current inputs, let logic settle, then compare.
  task automatic settle();
    logic [32:0] e;
    exp_q.push_back(model_read(raddr[AW-1:0]));
    exp_q.push_back(model_read(raddr[2*AW-1:AW]));
    #2;
    for (int j = 0; j < 2; j++) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: got no entry expected entry for port %0d", j);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("rdata%0d", j), rdata[j*DW +: DW], e[31:0]);
        check($sformatf("rbusy%0d", j), {31'd0, rbusy[j]}, {31'd0, e[32]});
      end
    end
    check("busy_vec", busy_vec, m_busy);
  endtask

  task automatic tick();
    if (reset) begin
      for (int k = 0; k < 32; k++) m_rf[k] = '0;
      m_busy = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (we[i] && waddr[i*AW +: AW] != '0) begin
          m_rf[waddr[i*AW +: AW]]   = wdata[i*DW +: DW];
          m_busy[waddr[i*AW +: AW]] = 1'b0;
        end
      end
      if (issue_valid && issue_addr != '0) m_busy[issue_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    raddr = '0;
    idle_inputs();
    for (int k = 0; k < 32; k++) m_rf[k] = '0;
    m_busy = '0;
    @(posedge clk);
    #1;
    tick();
    reset = 1'b0;

    // Every address reads zero and not busy after reset.
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(31 - a), 5'(a)};
      settle();
    end
    check("rst_busy_vec", busy_vec, 32'd0);

    // Same-cycle forwarding, then array read.
    drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);
    settle();
    check("fwd5", rdata[DW-1:0], 32'hDEADBEEF);
    tick();
    idle_inputs();
    settle();
    check("arr5", rdata[2*DW-1:DW], 32'hDEADBEEF);

    // Collision: port 1 wins in both forwarding and storage.
    drive(2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222, 1'b0, 5'd0, 5'd7, 5'd5);
    settle();
    check("fwd7", rdata[DW-1:0], 32'h22222222);
    tick();
    idle_inputs();
    settle();
    check("arr7", rdata[DW-1:0], 32'h22222222);

    // Register zero ignores writes and issues.
    drive(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);
    settle();
    check("zero_fwd", rdata[DW-1:0], 32'd0);
    tick();
    idle_inputs();
    settle();
    check("zero_arr", rdata[DW-1:0], 32'd0);
    check("zero_busy", {31'd0, busy_vec[0]}, 32'd0);

    // Scoreboard: issue 9, pending for two cycles, cleared by the write.
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd9);
    settle();
    check("iss9_c0", {31'd0, rbusy[0]}, 32'd0);
    tick();
    idle_inputs();
    for (int c = 1; c < 3; c++) begin
      settle();
      check("iss9_pend", {31'd0, rbusy[0]}, 32'd1);
      tick();
    end
    drive(2'b10, 5'd0, 32'd0, 5'd9, 32'h00000099, 1'b0, 5'd0, 5'd9, 5'd9);
    settle();
    check("wr9_rbusy", {31'd0, rbusy[1]}, 32'd0);
    check("wr9_data", rdata[2*DW-1:DW], 32'h00000099);
    tick();
    idle_inputs();
    settle();
    check("wr9_clear", {31'd0, busy_vec[9]}, 32'd0);
    // Issue and write to the same register: issue wins.
    drive(2'b01, 5'd9, 32'h0000AAAA, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd9);
    settle();
    tick();
    idle_inputs();
    settle();
    check("set_wins", {31'd0, busy_vec[9]}, 32'd1);
    check("set_wins_data", rdata[DW-1:0], 32'h0000AAAA);

    // Reset aborts everything in flight.
    drive(2'b01, 5'd12, 32'h0000ABCD, 5'd0, 32'd0, 1'b1, 5'd12, 5'd12, 5'd12);
    settle();
    tick();
    idle_inputs();
    reset = 1'b1;
    drive(2'b10, 5'd0, 32'd0, 5'd12, 32'h12345678, 1'b1, 5'd13, 5'd12, 5'd12);
    settle();
    tick();
    reset = 1'b0;
    idle_inputs();
    settle();
    check("rst12_data", rdata[DW-1:0], 32'd0);
    check("rst12_busy", busy_vec, 32'd0);

    // Random traffic, with narrow address ranges to force collisions.
    for (int n = 0; n < 300; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive(2'($urandom_range(0, 3)),
            5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      settle();
      tick();
    end
    reset = 1'b0;

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
